vec_cla_adder_pipe: RTL and testbench

- Pipelined, lane-segmented carry-lookahead adder/subtractor for the vector unit.
- Generalises the single-level carry unit:
  - two-level lookahead over WIDTH bits in BLOCK-bit groups;
  - runtime element width (SEW) with carry chains cut at lane boundaries;
  - per-lane carry/borrow in and out (vadd/vsub/vadc/vsbc/vmadc semantics);
  - two-stage valid/ready pipeline.
- Sits between the vector operand-read stage and the writeback mux.

---
 rtl/vec_cla_adder_pipe.sv | 226 ++++++++++++++++++++++
 tb/tb_vec_cla_adder_pipe.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vec_cla_adder_pipe.sv
// vec_cla_adder_pipe: two-stage, lane-segmented carry-lookahead adder/subtractor.
// Stage 1 conditions operands and resolves group carry-ins across the whole
// datapath, cutting the chain at each lane boundary. Stage 2 ripples carries
// inside each BLOCK-bit group and forms lane sums and carry/borrow-outs.
// Mode bits (sub, sew) travel with each operation through both stages.
module vec_cla_adder_pipe #(
    parameter  int WIDTH  = 64,
    parameter  int BLOCK  = 4,
    localparam int NBYTES = WIDTH / 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [WIDTH-1:0]  a_i,
    input  logic [WIDTH-1:0]  b_i,
    input  logic [NBYTES-1:0] carry_i,
    input  logic              sub_i,
    input  logic [1:0]        sew_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [WIDTH-1:0]  sum_o,
    output logic [NBYTES-1:0] cout_o
);

    localparam int NGROUPS = WIDTH / BLOCK;
    localparam int GPB     = 8 / BLOCK;   // lookahead groups per byte

    // True when byte index byte_idx is the least-significant byte of a lane.
    // 64b lanes on a datapath narrower than 64 bits collapse to one lane.
    function automatic logic is_lane_lsb(input int byte_idx, input logic [1:0] sew);
        case (sew)
            2'b00:   is_lane_lsb = 1'b1;
            2'b01:   is_lane_lsb = (byte_idx % 2) == 0;
            2'b10:   is_lane_lsb = (byte_idx % 4) == 0;
            default: is_lane_lsb = (WIDTH >= 64) ? ((byte_idx % 8) == 0) : (byte_idx == 0);
        endcase
    endfunction

    // Most-significant byte of the lane whose least-significant byte is lsb,
    // clipped to the datapath for a partial top lane.
    function automatic int lane_msb(input int lsb, input logic [1:0] sew);
        int last;
        case (sew)
            2'b00:   last = lsb;
            2'b01:   last = lsb + 1;
            2'b10:   last = lsb + 3;
            default: last = (WIDTH >= 64) ? (lsb + 7) : (NBYTES - 1);
        endcase
        if (last > NBYTES - 1) begin
            last = NBYTES - 1;
        end
        lane_msb = last;
    endfunction

    // ------------------------------------------------------------------
    // Handshake and pipeline occupancy
    // ------------------------------------------------------------------
    logic s1_valid_q, s1_valid_d;
    logic s2_valid_q, s2_valid_d;
    logic s1_adv;
    logic s1_load;
    logic s2_load;

    assign s1_adv     = !s2_valid_q || out_ready_i;
    assign in_ready_o = !s1_valid_q || s1_adv;
    assign s1_load    = in_valid_i && in_ready_o && !flush_i;
    assign s2_load    = s1_valid_q && s1_adv && !flush_i;

    // Valid next-state: flush empties both stages, otherwise each stage fills or drains.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        s1_valid_d = s1_valid_q;
        s2_valid_d = s2_valid_q;
        if (flush_i) begin
            s1_valid_d = 1'b0;
            s2_valid_d = 1'b0;
        end else begin
            if (in_ready_o) begin
                s1_valid_d = in_valid_i;
            end
            if (s1_adv) begin
                s2_valid_d = s1_valid_q;
            end
        end
    end

    // Stage valid flags.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst_ni) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
        end
    end

    // ------------------------------------------------------------------
    // Operand conditioning and first-level lookahead
    // ------------------------------------------------------------------
    logic [WIDTH-1:0]   b_eff;
    logic [WIDTH-1:0]   g_d;
    logic [WIDTH-1:0]   p_d;
    logic [NGROUPS-1:0] grp_g;
    logic [NGROUPS-1:0] grp_p;
    logic [NGROUPS-1:0] gcin_d;

    // Subtraction is A + ~B + ~borrow; per-bit generate/propagate follow.
    always_comb begin
        b_eff = sub_i ? ~b_i : b_i;
        g_d   = a_i & b_eff;
        p_d   = a_i ^ b_eff;
    end

    // Per-group generate/propagate over BLOCK bits.
    always_comb begin
        logic gen_acc;
        logic prop_acc;
        gen_acc  = 1'b0;
        prop_acc = 1'b1;
        grp_g    = '0;
        grp_p    = '0;
        for (int k = 0; k < NGROUPS; k++) begin
            gen_acc  = 1'b0;
            prop_acc = 1'b1;
            for (int j = 0; j < BLOCK; j++) begin
                gen_acc  = g_d[k*BLOCK+j] | (p_d[k*BLOCK+j] & gen_acc);
                prop_acc = prop_acc & p_d[k*BLOCK+j];
            end
            grp_g[k] = gen_acc;
            grp_p[k] = prop_acc;
        end
    end

    // Second level: group carry-ins; a lane boundary drops the previous group's
    // contribution and injects that lane's conditioned carry-in instead.
    always_comb begin
        logic carry_acc;
        carry_acc = 1'b0;
        gcin_d    = '0;
        for (int k = 0; k < NGROUPS; k++) begin
            if (((k % GPB) == 0) && is_lane_lsb(k / GPB, sew_i)) begin
                carry_acc = carry_i[k/GPB] ^ sub_i;
            end
            gcin_d[k] = carry_acc;
            carry_acc = grp_g[k] | (grp_p[k] & carry_acc);
        end
    end

    // ------------------------------------------------------------------
    // Stage 1 registers
    // ------------------------------------------------------------------
    logic [WIDTH-1:0]   p_q;
    logic [WIDTH-1:0]   g_q;
    logic [NGROUPS-1:0] gcin_q;
    logic               sub_q;
    logic [1:0]         sew_q;

    // Stage-1 payload captured on accept; held while stage 2 is stalled.
    always_ff @(posedge clk_i) begin
        // NOTE: this payload is only consumed when s1_valid_q is set, so it carries no reset.
        if (s1_load) begin
            p_q    <= p_d;
            g_q    <= g_d;
            gcin_q <= gcin_d;
            sub_q  <= sub_i;
            sew_q  <= sew_i;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: in-group carries, sums, lane carry-outs
    // ------------------------------------------------------------------
    logic [WIDTH-1:0]  sum_d;
    logic [NBYTES-1:0] cout_d;
    logic [NBYTES-1:0] byte_co;   // carry out of each byte's MSB
    logic [WIDTH-1:0]  sum_q;
    logic [NBYTES-1:0] cout_q;

    // Ripple inside each group from its carry-in, then report each lane's
    // carry-out (inverted to a borrow for subtraction) at its LSB byte.
    always_comb begin
        logic carry_acc;
        int   bit_idx;
        carry_acc = 1'b0;
        bit_idx   = 0;
        sum_d     = '0;
        cout_d    = '0;
        byte_co   = '0;
        for (int k = 0; k < NGROUPS; k++) begin
            carry_acc = gcin_q[k];
            for (int j = 0; j < BLOCK; j++) begin
                bit_idx        = k * BLOCK + j;
                sum_d[bit_idx] = p_q[bit_idx] ^ carry_acc;
                carry_acc      = g_q[bit_idx] | (p_q[bit_idx] & carry_acc);
                if ((bit_idx % 8) == 7) begin
                    byte_co[bit_idx/8] = carry_acc;
                end
            end
        end
        for (int i = 0; i < NBYTES; i++) begin
            if (is_lane_lsb(i, sew_q)) begin
                cout_d[i] = byte_co[lane_msb(i, sew_q)] ^ sub_q;
            end
        end
    end

    // Result registers: load on advance, hold while the consumer stalls or on flush.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sum_q  <= '0;
            cout_q <= '0;
        end else if (s2_load) begin
            sum_q  <= sum_d;
            cout_q <= cout_d;
        end
    end

    assign out_valid_o = s2_valid_q;
    assign sum_o       = sum_q;
    assign cout_o      = cout_q;

endmodule

// File: tb/tb_vec_cla_adder_pipe.sv
// tb_vec_cla_adder_pipe: directed and randomized checks of vec_cla_adder_pipe
// (WIDTH = 64, BLOCK = 4) against a lane-wise arithmetic reference model and
// an in-order scoreboard of accepted operations.
module tb_vec_cla_adder_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] a_in;
    logic [63:0] b_in;
    logic [7:0]  carry_in;
    logic        sub_in;
    logic [1:0]  sew_in;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] sum;
    logic [7:0]  cout;

    always #5 clk = ~clk;

    vec_cla_adder_pipe #(.WIDTH(64), .BLOCK(4)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .flush_i     (flush),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .a_i         (a_in),
        .b_i         (b_in),
        .carry_i     (carry_in),
        .sub_i       (sub_in),
        .sew_i       (sew_in),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .sum_o       (sum),
        .cout_o      (cout)
    );

    typedef struct {
        logic [63:0] sum;
        logic [7:0]  cout;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          tests = 0;
    int          fails = 0;
    int          cyc   = 0;
    logic [63:0] nxt_sum;
    logic [7:0]  nxt_cout;
    logic        saw_block = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    // Lane-wise reference: each lane is an independent SEW-bit add/subtract.
    function automatic void ref_model(input logic [63:0] a, input logic [63:0] b,
                                      input logic [7:0] cin, input logic sub,
                                      input logic [1:0] sew,
                                      output logic [63:0] s, output logic [7:0] co);
        int          lb;
        int          lw;
        logic [64:0] mask;
        logic [64:0] av;
        logic [64:0] bv;
        logic [64:0] cv;
        logic [64:0] r;
        lb   = 1 << sew;
        lw   = 8 * lb;
        mask = (65'd1 << lw) - 65'd1;
        s    = '0;
        co   = '0;
        for (int l = 0; l < 8; l += lb) begin
            av = ({1'b0, a} >> (8 * l)) & mask;
            bv = ({1'b0, b} >> (8 * l)) & mask;
            cv = {64'd0, cin[l]};
            if (!sub) begin
                r     = av + bv + cv;
                co[l] = r[lw];
            end else begin
                r     = av - bv - cv;
                co[l] = (av < (bv + cv));
            end
            s = s | 64'((r & mask) << (8 * l));
        end
    endfunction

    task automatic set_op(input logic [63:0] a, input logic [63:0] b, input logic [7:0] c,
                          input logic s, input logic [1:0] w);
        a_in     = a;
        b_in     = b;
        carry_in = c;
        sub_in   = s;
        sew_in   = w;
        ref_model(a, b, c, s, w, nxt_sum, nxt_cout);
    endtask

    task automatic rand_op();
        logic [63:0] a;
        logic [63:0] b;
        a = {$urandom(), $urandom()};
        case ($urandom_range(0, 3))
            0:       b = ~a;
            1:       b = 64'hFFFF_FFFF_FFFF_FFFF;
            default: b = {$urandom(), $urandom()};
        endcase
        set_op(a, b, 8'($urandom()), 1'($urandom()), 2'($urandom()));
    endtask

    // One clock cycle: sample just after the falling edge, check handshake and
    // output against the scoreboard, record accepts, then advance.
    task automatic tick(output logic acc);
        logic exp_rdy;
        logic exp_vld;
        #1;
        exp_rdy = (sb.size() < 2) || out_ready;
        exp_vld = (sb.size() == 2) || ((sb.size() == 1) && ((cyc - sb[0].cyc) >= 2));
        check("in_ready", {63'd0, in_ready}, {63'd0, exp_rdy});
        check("out_valid", {63'd0, out_valid}, {63'd0, exp_vld});
        if (in_valid && !in_ready) saw_block = 1'b1;
        if (out_valid && (sb.size() > 0)) begin
            check("sum", sum, sb[0].sum);
            check("cout", {56'd0, cout}, {56'd0, sb[0].cout});
            if (out_ready) void'(sb.pop_front());
        end
        acc = in_valid && in_ready && !flush;
        if (flush) sb.delete();
        else if (acc) sb.push_back('{nxt_sum, nxt_cout, cyc});
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic idle(input int n);
        logic acc;
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) tick(acc);
    endtask

    task automatic send_op();
        logic acc;
        int   n;
        n        = 0;
        acc      = 1'b0;
        in_valid = 1'b1;
        do begin
            tick(acc);
            n++;
        end while (!acc && (n < 20));
        check("accepted", {63'd0, acc}, 64'd1);
        in_valid = 1'b0;
    endtask

    initial begin
        logic        acc;
        int          sent;
        logic [63:0] hold_sum;

        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        set_op(64'd0, 64'd0, 8'd0, 1'b0, 2'b00);

        // Reset / idle
        repeat (2) @(negedge clk);
        #1;
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_sum", sum, 64'd0);
        check("rst_cout", {56'd0, cout}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        check("rel_in_ready", {63'd0, in_ready}, 64'd1);
        idle(2);

        // 64b add with full carry ripple
        set_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 8'h00, 1'b0, 2'b11);
        nxt_sum  = 64'h0;
        nxt_cout = 8'h01;
        send_op();
        idle(3);

        // Back-to-back ops with different SEW: 8b, 16b, 32b subtract with borrow
        set_op(64'h80FF_80FF_80FF_80FF, 64'h8001_8001_8001_8001, 8'h00, 1'b0, 2'b00);
        nxt_sum  = 64'h0;
        nxt_cout = 8'hFF;
        send_op();
        set_op(64'h80FF_80FF_80FF_80FF, 64'h8001_8001_8001_8001, 8'h00, 1'b0, 2'b01);
        nxt_sum  = 64'h0100_0100_0100_0100;
        nxt_cout = 8'h55;
        send_op();
        set_op(64'h0000_0005_0000_0000, 64'h0000_0003_0000_0001, 8'h11, 1'b1, 2'b10);
        nxt_sum  = 64'h0000_0001_FFFF_FFFE;
        nxt_cout = 8'h01;
        send_op();
        idle(4);

        // Back-pressure: four ops, consumer stalls for cycles 3-5
        sent      = 0;
        saw_block = 1'b0;
        in_valid  = 1'b0;
        for (int i = 0; i < 12; i++) begin
            out_ready = !((i >= 3) && (i <= 5));
            if ((sent < 4) && !in_valid) begin
                rand_op();
                in_valid = 1'b1;
            end
            tick(acc);
            if (acc) begin
                sent++;
                in_valid = 1'b0;
            end
        end
        out_ready = 1'b1;
        check("bp_in_ready_dropped", {63'd0, saw_block}, 64'd1);
        check("bp_sent", 64'(sent), 64'd4);
        check("bp_drained", 64'(sb.size()), 64'd0);

        // Flush with two ops in flight and a new op presented
        rand_op();
        in_valid = 1'b1;
        tick(acc);
        rand_op();
        tick(acc);
        hold_sum  = sb[0].sum;
        out_ready = 1'b0;
        flush     = 1'b1;
        rand_op();
        tick(acc);
        flush    = 1'b0;
        in_valid = 1'b0;
        tick(acc);
        #1;
        check("flush_out_valid", {63'd0, out_valid}, 64'd0);
        check("flush_sum_held", sum, hold_sum);
        out_ready = 1'b1;
        idle(3);

        // Randomized traffic with random stalls and rare flushes
        for (int i = 0; i < 400; i++) begin
            out_ready = ($urandom_range(0, 9) < 7);
            flush     = ($urandom_range(0, 63) == 0);
            if (!in_valid && ($urandom_range(0, 9) < 8)) begin
                rand_op();
                in_valid = 1'b1;
            end
            tick(acc);
            if (acc || flush) in_valid = 1'b0;
        end
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; (i < 10) && (sb.size() > 0); i++) tick(acc);
        check("rand_drained", 64'(sb.size()), 64'd0);

        // Reset asserted while an op sits in stage 2
        rand_op();
        in_valid = 1'b1;
        tick(acc);
        in_valid = 1'b0;
        tick(acc);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", {63'd0, out_valid}, 64'd0);
        check("midrst_sum", sum, 64'd0);
        check("midrst_cout", {56'd0, cout}, 64'd0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        idle(3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
